mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and load/store (MEM stage).
//  Sits between the pipeline and the unified instruction/data memory.
//  Allows one outstanding transaction. Data access has priority; a streak counter prevents fetch starvation.
//  The pipeline stalls the requesting stage until that stage's rvalid arrives.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and the memory side
//  DATA_W        32  data width; byte-enable width is DATA_W/8
//  MAX_D_STREAK   4  max consecutive data grants while fetch is waiting (>=1)
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-high reset
//  if_req      in   1         fetch request; held with if_addr until if_gnt
//  if_addr     in   ADDR_W    fetch address
//  if_gnt      out  1         1-cycle pulse: fetch request accepted
//  if_rvalid   out  1         1-cycle pulse: if_rdata valid
//  if_rdata    out  DATA_W    fetched instruction
//  d_req       in   1         data request; held with d_* until d_gnt
//  d_we        in   1         1=store, 0=load
//  d_be        in   DATA_W/8  byte enables for a store
//  d_addr      in   ADDR_W    data address
//  d_wdata     in   DATA_W    store data
//  d_gnt       out  1         1-cycle pulse: data request accepted
//  d_rvalid    out  1         1-cycle pulse: load data valid or store complete
//  d_rdata     out  DATA_W    load data
//  mem_req     out  1         memory request; held until mem_gnt
//  mem_we      out  1         write strobe to memory
//  mem_be      out  DATA_W/8  byte enables to memory
//  mem_addr    out  ADDR_W    memory address
//  mem_wdata   out  DATA_W    memory write data
//  mem_gnt     in   1         memory accepted the request
//  mem_rvalid  in   1         memory response; also sent for writes
//  mem_rdata   in   DATA_W    memory read data
//  busy        out  1         1 whenever state != IDLE
// BEHAVIOUR
//  Reset:
//  - All outputs go to 0 immediately, including rdata. State=IDLE, owner=IF, streak=0.
//  - Any in-flight transaction is abandoned; a late mem_rvalid arriving in IDLE is ignored.
//  Outputs: all are registered. mem_* come from a request register latched at grant time.
//  FSM IDLE -> REQ -> RESP -> IDLE:
//  - IDLE: if any req is high, pick the winner, latch its fields and owner, go to REQ.
//    In the next cycle the winner's *_gnt pulses and mem_req=1.
//  - REQ: hold mem_req and fields until mem_gnt.
//    On mem_gnt & !mem_rvalid: go to RESP.
//    On mem_gnt & mem_rvalid: go to IDLE, delivering the response as below.
//  - RESP: wait for mem_rvalid (no timeout). Then go to IDLE.
//    Next cycle: owner's *_rvalid=1 and *_rdata=mem_rdata (held until overwritten).
//  - mem_rvalid is ignored in IDLE and REQ-without-mem_gnt. req lines are ignored outside IDLE.
//  Arbitration (IDLE only):
//  - Only one request: that one wins.
//  - Both requests: data wins unless streak==MAX_D_STREAK, in which case fetch wins.
//  Streak counter:
//  - Increments on a data grant when if_req=1.
//  - Clears on a fetch grant, and on a data grant when if_req=0.
//  - Saturates at MAX_D_STREAK.
//  Latency:
//  - req in cycle N -> gnt and mem_req in N+1.
//  - mem_rvalid in cycle M -> rvalid in M+1.
//  - A new req may be accepted in M+1 (back-to-back). Minimum round trip is 2 cycles.
//  Requester obligations: drop or change req only after its gnt; accept rvalid without backpressure.
// TESTING
//  1 Reset: reset=1 mid-RESP, then mem_rvalid=1 -> no rvalid; all outputs 0; busy=0.
//  2 Single fetch: if_req, addr=0x10, 1-cycle memory returning 0x00500093 -> if_gnt at N+1;
//    mem_addr=0x10 with mem_we=0; if_rvalid with rdata=0x00500093 at N+2.
//  3 Store: d_req, we=1, be=4'b0011, addr=0x100, wdata=0xDEADBEEF, mem_gnt delayed 3 cycles ->
//    mem_req held 3 cycles with stable fields; d_rvalid 1 cycle after mem_rvalid; if_* silent.
//  4 Collision: if_req and d_req rise together -> data granted first; fetch granted in the IDLE
//    cycle after d_rvalid.
//  5 Starvation: if_req held while d_req is re-asserted each IDLE, MAX_D_STREAK=4 ->
//    exactly 4 data grants, then 1 fetch grant, streak=0, then data resumes.
//  6 Back-to-back: new d_req asserted in the d_rvalid cycle -> d_gnt 1 cycle later; no idle gap
//    beyond IDLE; no double grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// in flight; data has priority, bounded by a streak counter so fetch cannot starve.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  logic [1:0]          state, state_nx;
  logic                owner_d, owner_d_nx;
  logic [STREAK_W-1:0] streak, streak_nx;
  mreq_t               mreq, mreq_nx;
  logic                mem_req_q, mem_req_nx;
  logic                if_gnt_q, if_gnt_nx;
  logic                d_gnt_q, d_gnt_nx;
  logic                if_rvalid_q, if_rvalid_nx;
  logic                d_rvalid_q, d_rvalid_nx;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_nx;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_nx;
  logic                busy_q, busy_nx;
  logic                pick_d;
  logic                deliver;

  // Next-state, arbitration and registered-output logic
  always_comb begin
    state_nx     = state;
    owner_d_nx   = owner_d;
    streak_nx    = streak;
    mreq_nx      = mreq;
    mem_req_nx   = mem_req_q;
    if_gnt_nx    = 1'b0;
    d_gnt_nx     = 1'b0;
    if_rvalid_nx = 1'b0;
    d_rvalid_nx  = 1'b0;
    if_rdata_nx  = if_rdata_q;
    d_rdata_nx   = d_rdata_q;
    deliver      = 1'b0;
    pick_d       = bus.d_req && !(bus.if_req && (streak == STREAK_W'(MAX_D_STREAK)));

    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_nx   = REQ;
          mem_req_nx = 1'b1;
          owner_d_nx = pick_d;
          if (pick_d) begin
            d_gnt_nx      = 1'b1;
            mreq_nx.we    = bus.d_we;
            mreq_nx.be    = bus.d_be;
            mreq_nx.addr  = bus.d_addr;
            mreq_nx.wdata = bus.d_wdata;
            // Streak only counts data grants that made a waiting fetch wait longer
            if (!bus.if_req) begin
              streak_nx = '0;
            end else if (streak != STREAK_W'(MAX_D_STREAK)) begin
              streak_nx = streak + STREAK_W'(1);
            end
          end else begin
            if_gnt_nx     = 1'b1;
            mreq_nx.we    = 1'b0;
            mreq_nx.be    = '0;
            mreq_nx.addr  = bus.if_addr;
            mreq_nx.wdata = '0;
            streak_nx     = '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          mem_req_nx = 1'b0;
          if (bus.mem_rvalid) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = RESP;
          end
        end
      end
      RESP: begin
        if (bus.mem_rvalid) begin
          deliver  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end
    endcase

    if (deliver) begin
      if (owner_d) begin
        d_rvalid_nx = 1'b1;
        d_rdata_nx  = bus.mem_rdata;
      end else begin
        if_rvalid_nx = 1'b1;
        if_rdata_nx  = bus.mem_rdata;
      end
    end

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      streak      <= '0;
      mreq        <= '0;
      mem_req_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      owner_d     <= owner_d_nx;
      streak      <= streak_nx;
      mreq        <= mreq_nx;
      mem_req_q   <= mem_req_nx;
      if_gnt_q    <= if_gnt_nx;
      d_gnt_q     <= d_gnt_nx;
      if_rvalid_q <= if_rvalid_nx;
      d_rvalid_q  <= d_rvalid_nx;
      if_rdata_q  <= if_rdata_nx;
      d_rdata_q   <= d_rdata_nx;
      busy_q      <= busy_nx;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mreq.we;
  assign bus.mem_be    = mreq.be;
  assign bus.mem_addr  = mreq.addr;
  assign bus.mem_wdata = mreq.wdata;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and a random-latency memory,
// checked every cycle against a transaction-level reference model with a shadow memory.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MAX_D_STREAK = 4;
  localparam int          NCYC         = 3000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D_STREAK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
    check({pfx, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    check({pfx, "_if_rdata"},  bus.if_rdata,       32'd0);
    check({pfx, "_d_gnt"},     32'(bus.d_gnt),     32'd0);
    check({pfx, "_d_rvalid"},  32'(bus.d_rvalid),  32'd0);
    check({pfx, "_d_rdata"},   bus.d_rdata,        32'd0);
    check({pfx, "_mem_req"},   32'(bus.mem_req),   32'd0);
    check({pfx, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({pfx, "_mem_be"},    32'(bus.mem_be),    32'd0);
    check({pfx, "_mem_addr"},  bus.mem_addr,       32'd0);
    check({pfx, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    check({pfx, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {24'h0, 6'($urandom), 2'b00};
  endfunction

  // Memory contents as seen by the memory agent, and the model's shadow copy
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  // Reference model: one transaction record plus held read data per requester
  bit          m_busy, m_acc, m_own_d;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, rd;
  int          m_streak;
  bit          take_d, done;
  bit          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;

  // Inputs as they stood during the cycle just closed
  logic        p_rst, p_if_req, p_d_req, p_d_we, p_mem_gnt, p_mem_rvalid;
  logic [3:0]  p_d_be;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata, p_mem_rdata;

  // Memory agent
  int          ag_phase, ag_cnt;
  logic [31:0] ag_addr;
  bit          late_rv, did_resp_rst, heavy, do_rst;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    m_busy = 0; m_acc = 0; m_own_d = 0; m_streak = 0;
    m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0;
    ag_phase = 0; ag_cnt = 0; ag_addr = '0;
    late_rv = 0; did_resp_rst = 0;

    @(posedge clock); @(posedge clock); #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      p_rst = reset; p_if_req = bus.if_req; p_if_addr = bus.if_addr;
      p_d_req = bus.d_req; p_d_we = bus.d_we; p_d_be = bus.d_be;
      p_d_addr = bus.d_addr; p_d_wdata = bus.d_wdata;
      p_mem_gnt = bus.mem_gnt; p_mem_rvalid = bus.mem_rvalid; p_mem_rdata = bus.mem_rdata;

      @(posedge clock); #1;

      // Model step: what the arbiter should have done with last cycle's inputs
      e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; done = 0;
      if (p_rst) begin
        m_busy = 0; m_acc = 0; m_streak = 0; m_if_rdata = '0; m_d_rdata = '0;
      end else if (!m_busy) begin
        if (p_if_req || p_d_req) begin
          take_d = p_d_req && !(p_if_req && m_streak == int'(MAX_D_STREAK));
          m_own_d = take_d;
          if (take_d) begin
            e_d_gnt = 1;
            m_we = p_d_we; m_be = p_d_be; m_addr = p_d_addr; m_wdata = p_d_wdata;
            if (!p_if_req) m_streak = 0;
            else if (m_streak < int'(MAX_D_STREAK)) m_streak = m_streak + 1;
          end else begin
            e_if_gnt = 1;
            m_we = 1'b0; m_be = '0; m_addr = p_if_addr; m_wdata = '0;
            m_streak = 0;
          end
          m_busy = 1; m_acc = 0;
        end
      end else if (!m_acc) begin
        if (p_mem_gnt) begin
          m_acc = 1;
          if (m_we) ref_mem[widx(m_addr)] = merge(ref_mem[widx(m_addr)], m_wdata, m_be);
          done = p_mem_rvalid;
        end
      end else begin
        done = p_mem_rvalid;
      end
      if (done) begin
        rd = ref_mem[widx(m_addr)];
        if (m_own_d) begin e_d_rv = 1; m_d_rdata = rd; end
        else begin e_if_rv = 1; m_if_rdata = rd; end
        m_busy = 0;
      end

      check("if_gnt",    32'(bus.if_gnt),    32'(e_if_gnt));
      check("d_gnt",     32'(bus.d_gnt),     32'(e_d_gnt));
      check("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
      check("d_rvalid",  32'(bus.d_rvalid),  32'(e_d_rv));
      check("if_rdata",  bus.if_rdata,       m_if_rdata);
      check("d_rdata",   bus.d_rdata,        m_d_rdata);
      check("busy",      32'(bus.busy),      32'(m_busy));
      check("mem_req",   32'(bus.mem_req),   32'(m_busy && !m_acc));
      if (m_busy && !m_acc) begin
        check("mem_addr", bus.mem_addr,    m_addr);
        check("mem_we",   32'(bus.mem_we), 32'(m_we));
        if (m_we) begin
          check("mem_be",    32'(bus.mem_be), 32'(m_be));
          check("mem_wdata", bus.mem_wdata,   m_wdata);
        end
      end

      // Reset once while a response is outstanding, otherwise rarely at random
      do_rst = (!did_resp_rst && ag_phase == 2 && cyc > 20) || ($urandom_range(0, 399) == 0);
      if (do_rst) begin
        if (ag_phase == 2) did_resp_rst = 1;
        reset = 1'b1;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        ag_phase = 0; late_rv = 1;
        #1;
        check_all_zero("async_rst");
      end else begin
        reset = 1'b0;
        heavy = ((cyc / 300) % 2) == 1;

        // Memory agent reacting to the arbiter's request lines
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
        if (late_rv) begin bus.mem_rvalid = 1'b1; late_rv = 0; end
        if (ag_phase == 0 && bus.mem_req) begin
          ag_phase = 1; ag_cnt = int'($urandom_range(0, 3));
        end
        if (ag_phase == 1) begin
          if (ag_cnt == 0) begin
            bus.mem_gnt = 1'b1;
            bus.mem_rvalid = 1'b0;
            ag_addr = bus.mem_addr;
            if (bus.mem_we) mem[widx(ag_addr)] = merge(mem[widx(ag_addr)], bus.mem_wdata, bus.mem_be);
            if ($urandom_range(0, 2) == 0) begin
              bus.mem_rvalid = 1'b1; bus.mem_rdata = mem[widx(ag_addr)]; ag_phase = 0;
            end else begin
              ag_phase = 2; ag_cnt = int'($urandom_range(0, 3));
            end
          end else begin
            ag_cnt--;
          end
        end else if (ag_phase == 2) begin
          if (ag_cnt == 0) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = mem[widx(ag_addr)]; ag_phase = 0;
          end else begin
            ag_cnt--;
          end
        end
        if (ag_phase != 2 && !bus.mem_gnt && !bus.mem_rvalid && $urandom_range(0, 7) == 0)
          bus.mem_rvalid = 1'b1;

        // Requesters hold their request until granted, then may issue a new one
        if (!bus.if_req || bus.if_gnt) begin
          bus.if_req  = heavy ? 1'b1 : 1'($urandom_range(0, 1));
          bus.if_addr = rand_addr();
        end
        if (!bus.d_req || bus.d_gnt) begin
          bus.d_req   = heavy ? 1'b1 : 1'($urandom_range(0, 9) < 6);
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_be    = 4'($urandom);
          bus.d_addr  = rand_addr();
          bus.d_wdata = $urandom;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
